// File: rtl/pi_compensator_pkg.sv
// ============================================================================
// pi_comp_pkg : shared state encoding and default constants for the PI loop
// Rev 1.0
// ============================================================================
`default_nettype none

package pi_comp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL_A = 3'd1,
    ST_MUL_B = 3'd2,
    ST_SAT   = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  localparam int FRAC          = 12;
  localparam int DEF_ERR_W     = 13;
  localparam int DEF_COEF_W    = 16;
  localparam int DEF_ACC_W     = 32;
  localparam int DEF_DUTY_W    = 10;
  localparam int DEF_COEF_A    = 2048;
  localparam int DEF_COEF_B    = -1843;
  localparam int DEF_DUTY_INIT = 512;
  localparam int DEF_DUTY_MIN  = 20;
  localparam int DEF_DUTY_MAX  = 1000;

endpackage

`default_nettype wire

// File: rtl/pi_compensator_if.sv
// ============================================================================
// pi_compensator_if : error-sample input and duty-command output bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface pi_compensator_if #(
  parameter int ERR_W  = 13,
  parameter int DUTY_W = 10
) ();
  logic                     ENABLE;
  logic signed [ERR_W-1:0]  ERR;
  logic                     ERR_VALID;
  logic        [DUTY_W-1:0] DUTY;
  logic                     DUTY_VALID;
  logic                     SAT_HI;
  logic                     SAT_LO;
  logic                     BUSY;
  logic                     OVERRUN;

  modport master (
    output ENABLE, ERR, ERR_VALID,
    input  DUTY, DUTY_VALID, SAT_HI, SAT_LO, BUSY, OVERRUN
  );

  modport slave (
    input  ENABLE, ERR, ERR_VALID,
    output DUTY, DUTY_VALID, SAT_HI, SAT_LO, BUSY, OVERRUN
  );
endinterface

`default_nettype wire

// File: rtl/dffa.sv
// ============================================================================
// dffa : W-bit D flip-flop with asynchronous active-high reset to RST_VAL
// Rev 1.0
// ============================================================================
`default_nettype none

module dffa #(
  parameter int         W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic [W-1:0] d,
  output logic      [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end
endmodule

`default_nettype wire

// File: rtl/pi_compensator_sat_clamp.sv
// ============================================================================
// sat_clamp : combinational signed clamp to [lim_lo, lim_hi] with hit flags
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_clamp #(
  parameter int W = 32
) (
  input  wire logic signed [W-1:0] value,
  input  wire logic signed [W-1:0] lim_lo,
  input  wire logic signed [W-1:0] lim_hi,
  output logic signed      [W-1:0] y,
  output logic                     hi,
  output logic                     lo
);
  always_comb begin
    y  = value;
    hi = 1'b0;
    lo = 1'b0;
    if (value > lim_hi) begin
      y  = lim_hi;
      hi = 1'b1;
    end else if (value < lim_lo) begin
      y  = lim_lo;
      lo = 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: rtl/pi_compensator.sv
// ============================================================================
// pi_compensator : velocity-form PI update with one shared multiplier,
//                  clamped accumulator (anti-windup) driving the DPWM duty.
// Rev 1.0
// ============================================================================
`default_nettype none

module pi_compensator
  import pi_comp_pkg::*;
#(
  parameter int ERR_W     = pi_comp_pkg::DEF_ERR_W,
  parameter int COEF_W    = pi_comp_pkg::DEF_COEF_W,
  parameter int FRAC      = pi_comp_pkg::FRAC,
  parameter int ACC_W     = pi_comp_pkg::DEF_ACC_W,
  parameter int DUTY_W    = pi_comp_pkg::DEF_DUTY_W,
  parameter int COEF_A    = pi_comp_pkg::DEF_COEF_A,
  parameter int COEF_B    = pi_comp_pkg::DEF_COEF_B,
  parameter int DUTY_INIT = pi_comp_pkg::DEF_DUTY_INIT,
  parameter int DUTY_MIN  = pi_comp_pkg::DEF_DUTY_MIN,
  parameter int DUTY_MAX  = pi_comp_pkg::DEF_DUTY_MAX
) (
  input  wire logic         CLK,
  input  wire logic         RSTp,
  pi_compensator_if.slave   bus
);

  localparam int PROD_W = COEF_W + ERR_W;
  localparam logic signed [ACC_W-1:0] ACC_INIT = ACC_W'(DUTY_INIT * (2 ** FRAC));
  localparam logic signed [ACC_W-1:0] LIM_LO   = ACC_W'(DUTY_MIN * (2 ** FRAC));
  localparam logic signed [ACC_W-1:0] LIM_HI   = ACC_W'(DUTY_MAX * (2 ** FRAC));

  logic [2:0] state_raw_q;
  state_e     state_q, state_d;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  sum_q, sum_d;
  logic signed [ERR_W-1:0]  e_q, e_d;
  logic signed [ERR_W-1:0]  e_prev_q, e_prev_d;
  logic        [DUTY_W-1:0] duty_q, duty_d;
  logic                     duty_valid_q, duty_valid_d;
  logic                     sat_hi_q, sat_hi_d;
  logic                     sat_lo_q, sat_lo_d;
  logic                     overrun_q, overrun_d;

  logic signed [COEF_W-1:0] mul_coef;
  logic signed [ERR_W-1:0]  mul_data;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  clamp_y;
  logic                     clamp_hi;
  logic                     clamp_lo;

  dffa #(.W(3), .RST_VAL(3'(ST_IDLE))) u_state_reg (
    .clk (CLK),
    .rst (RSTp),
    .d   (state_d),
    .q   (state_raw_q)
  );
  assign state_q = state_e'(state_raw_q);

  // One multiplier: MUL_B uses COEF_B*e_prev, every other state COEF_A*e.
  always_comb begin
    mul_coef = COEF_W'(COEF_A);
    mul_data = e_q;
    if (state_q == ST_MUL_B) begin
      mul_coef = COEF_W'(COEF_B);
      mul_data = e_prev_q;
    end
  end

  assign prod     = mul_coef * mul_data;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  sat_clamp #(.W(ACC_W)) u_sat_clamp (
    .value  (sum_q),
    .lim_lo (LIM_LO),
    .lim_hi (LIM_HI),
    .y      (clamp_y),
    .hi     (clamp_hi),
    .lo     (clamp_lo)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    sum_d        = sum_q;
    e_d          = e_q;
    e_prev_d     = e_prev_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    sat_hi_d     = sat_hi_q;
    sat_lo_d     = sat_lo_q;
    overrun_d    = overrun_q | (bus.ERR_VALID & (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (!bus.ENABLE) begin
          acc_d    = ACC_INIT;
          e_prev_d = '0;
          duty_d   = DUTY_W'(DUTY_INIT);
        end else if (bus.ERR_VALID) begin
          e_d     = bus.ERR;
          state_d = ST_MUL_A;
        end
      end
      ST_MUL_A: begin
        sum_d   = acc_q + prod_ext;
        state_d = ST_MUL_B;
      end
      ST_MUL_B: begin
        sum_d   = sum_q + prod_ext;
        state_d = ST_SAT;
      end
      ST_SAT: begin
        // Clamped value replaces the accumulator so the integrator cannot wind up.
        acc_d        = clamp_y;
        sat_hi_d     = clamp_hi;
        sat_lo_d     = clamp_lo;
        e_prev_d     = e_q;
        duty_d       = clamp_y[FRAC+DUTY_W-1:FRAC];
        duty_valid_d = 1'b1;
        state_d      = ST_OUT;
      end
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RSTp) begin
    if (RSTp) begin
      acc_q        <= ACC_INIT;
      sum_q        <= '0;
      e_q          <= '0;
      e_prev_q     <= '0;
      duty_q       <= DUTY_W'(DUTY_INIT);
      duty_valid_q <= 1'b0;
      sat_hi_q     <= 1'b0;
      sat_lo_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      sum_q        <= sum_d;
      e_q          <= e_d;
      e_prev_q     <= e_prev_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      sat_hi_q     <= sat_hi_d;
      sat_lo_q     <= sat_lo_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.DUTY       = duty_q;
  assign bus.DUTY_VALID = duty_valid_q;
  assign bus.SAT_HI     = sat_hi_q;
  assign bus.SAT_LO     = sat_lo_q;
  assign bus.BUSY       = (state_q != ST_IDLE);
  assign bus.OVERRUN    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_pi_compensator.sv
// ============================================================================
// tb_pi_compensator : scoreboard bench for a unity-gain and a default-gain DUT
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pi_compensator;

  typedef struct packed {
    logic [9:0] duty;
    logic       hi;
    logic       lo;
  } exp_t;

  logic CLK  = 1'b0;
  logic RSTp = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vcnt_g   = 0;
  int   vcnt_d   = 0;
  exp_t q_g[$];
  exp_t q_d[$];

  always #5 CLK = ~CLK;

  pi_compensator_if #(.ERR_W(13), .DUTY_W(10)) bus_g ();
  pi_compensator_if #(.ERR_W(13), .DUTY_W(10)) bus_d ();

  pi_compensator #(.COEF_A(4096), .COEF_B(0)) dut_gain (
    .CLK  (CLK),
    .RSTp (RSTp),
    .bus  (bus_g.slave)
  );

  pi_compensator dut_def (
    .CLK  (CLK),
    .RSTp (RSTp),
    .bus  (bus_d.slave)
  );

  always @(negedge CLK) begin
    exp_t ex;
    if (bus_g.DUTY_VALID === 1'b1) begin
      vcnt_g++;
      n_checks++;
      if (q_g.size() == 0) begin
        $display("FAIL gain_unexpected_valid: DUTY=%0d with no update pending", bus_g.DUTY);
      end else begin
        ex = q_g.pop_front();
        if ({bus_g.DUTY, bus_g.SAT_HI, bus_g.SAT_LO} !== {ex.duty, ex.hi, ex.lo})
          $display("FAIL gain_update: DUTY=%0d HI=%b LO=%b, want DUTY=%0d HI=%b LO=%b",
                   bus_g.DUTY, bus_g.SAT_HI, bus_g.SAT_LO, ex.duty, ex.hi, ex.lo);
        else n_pass++;
      end
    end
  end

  always @(negedge CLK) begin
    exp_t ex;
    if (bus_d.DUTY_VALID === 1'b1) begin
      vcnt_d++;
      n_checks++;
      if (q_d.size() == 0) begin
        $display("FAIL def_unexpected_valid: DUTY=%0d with no update pending", bus_d.DUTY);
      end else begin
        ex = q_d.pop_front();
        if ({bus_d.DUTY, bus_d.SAT_HI, bus_d.SAT_LO} !== {ex.duty, ex.hi, ex.lo})
          $display("FAIL def_update: DUTY=%0d HI=%b LO=%b, want DUTY=%0d HI=%b LO=%b",
                   bus_d.DUTY, bus_d.SAT_HI, bus_d.SAT_LO, ex.duty, ex.hi, ex.lo);
        else n_pass++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a cycle start (posedge + 1); returns one cycle later.
  task automatic strobe_g(input int e, input int duty, input bit hi, input bit lo, input bit push);
    bus_g.ERR       = 13'(e);
    bus_g.ERR_VALID = 1'b1;
    if (push) q_g.push_back('{10'(duty), hi, lo});
    @(posedge CLK) #1;
    bus_g.ERR_VALID = 1'b0;
  endtask

  task automatic strobe_d(input int e, input int duty, input bit hi, input bit lo, input bit push);
    bus_d.ERR       = 13'(e);
    bus_d.ERR_VALID = 1'b1;
    if (push) q_d.push_back('{10'(duty), hi, lo});
    @(posedge CLK) #1;
    bus_d.ERR_VALID = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && (q_g.size() != 0 || q_d.size() != 0); i++) @(posedge CLK);
    #1;
    n_checks++;
    if (q_g.size() != 0 || q_d.size() != 0)
      $display("FAIL %s_drain: pending gain=%0d def=%0d, want 0/0", name, q_g.size(), q_d.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    RSTp = 1'b1;
    idle_cycles(3);
    n_checks++;
    if ({bus_g.DUTY, bus_g.DUTY_VALID, bus_g.SAT_HI, bus_g.SAT_LO, bus_g.BUSY, bus_g.OVERRUN}
        !== {10'd512, 5'b0})
      $display("FAIL reset_gain: DUTY=%0d V=%b HI=%b LO=%b BUSY=%b OVR=%b, want 512 and zeros",
               bus_g.DUTY, bus_g.DUTY_VALID, bus_g.SAT_HI, bus_g.SAT_LO, bus_g.BUSY, bus_g.OVERRUN);
    else n_pass++;
    n_checks++;
    if ({bus_d.DUTY, bus_d.DUTY_VALID, bus_d.SAT_HI, bus_d.SAT_LO, bus_d.BUSY, bus_d.OVERRUN}
        !== {10'd512, 5'b0})
      $display("FAIL reset_def: DUTY=%0d V=%b HI=%b LO=%b BUSY=%b OVR=%b, want 512 and zeros",
               bus_d.DUTY, bus_d.DUTY_VALID, bus_d.SAT_HI, bus_d.SAT_LO, bus_d.BUSY, bus_d.OVERRUN);
    else n_pass++;
    @(negedge CLK);
    RSTp = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_gain();
    bus_g.ERR       = 13'sd8;
    bus_g.ERR_VALID = 1'b1;
    q_g.push_back('{10'd520, 1'b0, 1'b0});
    @(negedge CLK);
    n_checks++;
    if (bus_g.BUSY !== 1'b0) $display("FAIL gain_busy_c0: BUSY=%b want 0", bus_g.BUSY);
    else n_pass++;
    @(posedge CLK) #1;
    bus_g.ERR_VALID = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      n_checks++;
      if (bus_g.BUSY !== (k <= 4) || bus_g.DUTY_VALID !== (k == 4))
        $display("FAIL gain_timing_c%0d: BUSY=%b V=%b, want BUSY=%b V=%b",
                 k, bus_g.BUSY, bus_g.DUTY_VALID, k <= 4, k == 4);
      else n_pass++;
    end
    wait_drain("gain");
  endtask

  task automatic test_low_clamp();
    strobe_g(-4096, 20, 1'b0, 1'b1, 1'b1);
    idle_cycles(6);
    strobe_g(1, 21, 1'b0, 1'b0, 1'b1);
    wait_drain("low_clamp");
    n_checks++;
    if (bus_g.SAT_LO !== 1'b0 || bus_g.DUTY !== 10'd21)
      $display("FAIL low_clamp_hold: DUTY=%0d LO=%b, want 21 and 0", bus_g.DUTY, bus_g.SAT_LO);
    else n_pass++;
  endtask

  task automatic test_default();
    strobe_d(100, 562, 1'b0, 1'b0, 1'b1);
    idle_cycles(6);
    strobe_d(100, 567, 1'b0, 1'b0, 1'b1);
    wait_drain("default");
  endtask

  task automatic test_enable();
    int v0;
    v0 = vcnt_d;
    bus_d.ENABLE = 1'b0;
    idle_cycles(2);
    for (int i = 0; i < 3; i++) begin
      strobe_d(300, 0, 1'b0, 1'b0, 1'b0);
      idle_cycles(1);
    end
    idle_cycles(6);
    n_checks++;
    if (bus_d.DUTY !== 10'd512 || bus_d.OVERRUN !== 1'b0 || bus_d.BUSY !== 1'b0 || vcnt_d != v0)
      $display("FAIL enable_hold: DUTY=%0d OVR=%b BUSY=%b pulses=%0d, want 512 0 0 0",
               bus_d.DUTY, bus_d.OVERRUN, bus_d.BUSY, vcnt_d - v0);
    else n_pass++;
    bus_d.ENABLE = 1'b1;
    idle_cycles(1);
    // Reload cleared acc and e_prev, so this matches the first post-reset update.
    strobe_d(100, 562, 1'b0, 1'b0, 1'b1);
    wait_drain("enable");
  endtask

  task automatic test_overrun();
    strobe_g(10, 31, 1'b0, 1'b0, 1'b1);
    @(posedge CLK) #1;
    strobe_g(50, 0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    n_checks++;
    if (bus_g.OVERRUN !== 1'b1) $display("FAIL overrun_set: OVERRUN=%b want 1", bus_g.OVERRUN);
    else n_pass++;
    wait_drain("overrun");
    idle_cycles(10);
    n_checks++;
    if (bus_g.OVERRUN !== 1'b1 || bus_g.DUTY !== 10'd31)
      $display("FAIL overrun_sticky: OVERRUN=%b DUTY=%0d, want 1 and 31", bus_g.OVERRUN, bus_g.DUTY);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int v0;
    v0 = vcnt_g;
    strobe_g(8, 0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK) #1;
    RSTp = 1'b1;
    #1;
    n_checks++;
    if (bus_g.DUTY !== 10'd512 || bus_g.BUSY !== 1'b0 || bus_g.DUTY_VALID !== 1'b0 || bus_g.OVERRUN !== 1'b0)
      $display("FAIL reset_mid_async: DUTY=%0d BUSY=%b V=%b OVR=%b, want 512 0 0 0",
               bus_g.DUTY, bus_g.BUSY, bus_g.DUTY_VALID, bus_g.OVERRUN);
    else n_pass++;
    @(negedge CLK);
    RSTp = 1'b0;
    idle_cycles(8);
    n_checks++;
    if (vcnt_g != v0 || bus_g.DUTY !== 10'd512 || bus_g.BUSY !== 1'b0)
      $display("FAIL reset_mid_abort: pulses=%0d DUTY=%0d BUSY=%b, want 0 512 0",
               vcnt_g - v0, bus_g.DUTY, bus_g.BUSY);
    else n_pass++;
    // Accumulator restarted from DUTY_INIT.
    strobe_g(8, 520, 1'b0, 1'b0, 1'b1);
    wait_drain("reset_mid");
  endtask

  initial begin
    bus_g.ENABLE = 1'b1;
    bus_g.ERR = '0;
    bus_g.ERR_VALID = 1'b0;
    bus_d.ENABLE = 1'b1;
    bus_d.ERR = '0;
    bus_d.ERR_VALID = 1'b0;
    test_reset();
    test_gain();
    test_low_clamp();
    test_default();
    test_enable();
    test_overrun();
    test_reset_mid();
    idle_cycles(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
